regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the multi-issue core pipeline; successor to the single-write, two-read file.
- Provides NRD combinational read ports and NWR write ports with same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard for pending writebacks (e.g. outstanding loads).
- Adds a sequenced post-reset clear with an init_done indication.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Provides the FSM state type and the address-width helper.
package regfile_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    function automatic int calc_aw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle of the multi-port register file.
// The pipeline drives the master side; the register file is the slave.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = calc_aw(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                busy_set;
    logic [AW-1:0]       busy_addr;
    logic                init_done;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output busy_set, busy_addr,
        input  rd_data, rd_busy, init_done
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  busy_set, busy_addr,
        output rd_data, rd_busy, init_done
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pending writebacks.
// A new producer (set) beats a completing writeback (clear).
module regfile_scoreboard #(
    parameter int NREGS    = 32,
    parameter int NWR      = 2,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_set,
    input  logic [AW-1:0]     i_set_addr,
    input  logic [NWR-1:0]    i_wr_en,
    input  logic [NWR*AW-1:0] i_wr_addr,
    output logic [NREGS-1:0]  o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_next;
    logic             w_set_ok;

    assign w_set_ok = i_set && !(ZERO_REG != 0 && i_set_addr == '0);

    always_comb begin
        w_next = r_busy;
        for (int j = 0; j < NWR; j++) begin
            if (i_wr_en[j]) begin
                w_next[i_wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (w_set_ok) begin
            w_next[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else if (i_en) begin
            r_busy <= w_next;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass,
// busy scoreboard and a sequenced post-reset clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    localparam int AW = calc_aw(NREGS);

    rf_state_e        r_state;
    logic [AW-1:0]    r_cnt;
    logic [XLEN-1:0]  r_mem [NREGS];
    logic             w_run;
    logic [NWR-1:0]   w_wr_act;
    logic [NREGS-1:0] w_busy;

    assign w_run         = (r_state == RUN);
    assign w_wr_act      = bus.wr_en & {NWR{w_run}};
    assign bus.init_done = w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else if (r_state == INIT) begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == AW'(NREGS - 1)) begin
                r_state <= RUN;
            end
        end
    end

    // Loop order makes the highest-index port win on address conflicts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_mem[r_cnt] <= '0;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (w_wr_act[j] &&
                        !(ZERO_REG != 0 && bus.wr_addr[j*AW +: AW] == '0)) begin
                        r_mem[bus.wr_addr[j*AW +: AW]] <=
                            bus.wr_data[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_run),
        .i_set      (bus.busy_set),
        .i_set_addr (bus.busy_addr),
        .i_wr_en    (w_wr_act),
        .i_wr_addr  (bus.wr_addr),
        .o_busy     (w_busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_hit;

        assign w_addr = bus.rd_addr[i*AW +: AW];

        always_comb begin
            w_hit  = 1'b0;
            w_data = r_mem[w_addr];
            for (int j = 0; j < NWR; j++) begin
                if (w_wr_act[j] && bus.wr_addr[j*AW +: AW] == w_addr) begin
                    w_hit  = 1'b1;
                    w_data = bus.wr_data[j*XLEN +: XLEN];
                end
            end
            if (!w_run || (ZERO_REG != 0 && w_addr == '0)) begin
                w_data = '0;
            end
        end

        assign bus.rd_data[i*XLEN +: XLEN] = w_data;
        assign bus.rd_busy[i] = w_run & w_busy[w_addr] & ~w_hit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: clear sequence, bypass,
// write conflicts, x0 handling, scoreboard and mid-run reset.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

    regfile_mp #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        bs;
        logic [4:0]  ba;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs [16];
    exp_t q_exp [$];

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0,
                         input logic [31:0] wd0, input logic [4:0] wa1,
                         input logic [31:0] wd1, input logic bs,
                         input logic [4:0] ba, input logic [4:0] ra0,
                         input logic [4:0] ra1);
        bus.wr_en     = we;
        bus.wr_addr   = {wa1, wa0};
        bus.wr_data   = {wd1, wd0};
        bus.busy_set  = bs;
        bus.busy_addr = ba;
        bus.rd_addr   = {ra1, ra0};
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    // Counts edges after rst release until init_done; pokes writes,
    // busy sets and reads during INIT, all of which must be ignored.
    task automatic run_init(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            drive(2'b11, 5'(cyc), 32'hA5A50000 + cyc, 5'd17, 32'hFFFF0000,
                  1'b1, 5'd4, 5'(cyc), 5'd17);
            @(negedge clk);
            if (!bus.init_done)
                chk("init_quiet", {28'd0, bus.rd_data, bus.rd_busy, 2'b00},
                    96'd0);
            @(posedge clk);
            #1;
            cyc++;
            if (bus.init_done) break;
        end
        idle();
        if (!bus.init_done) begin
            n_chk++;
            n_fail++;
            $display("FAIL init_timeout: got init_done=0 expected 1");
        end
    endtask

    initial begin
        int   cyc;
        exp_t ex;

        vecs[0]  = '{2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0,
                     32'hDEADBEEF, 0, 2'b00};
        vecs[1]  = '{2'b00, 0, 0, 0, 0, 0, 0, 5, 6,
                     32'hDEADBEEF, 0, 2'b00};
        vecs[2]  = '{2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 7,
                     32'h22, 32'h22, 2'b00};
        vecs[3]  = '{2'b00, 0, 0, 0, 0, 0, 0, 7, 5,
                     32'h22, 32'hDEADBEEF, 2'b00};
        vecs[4]  = '{2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0,
                     0, 0, 2'b00};
        vecs[5]  = '{2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00};
        vecs[6]  = '{2'b00, 0, 0, 0, 0, 1, 9, 9, 9, 0, 0, 2'b00};
        vecs[7]  = '{2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 2'b11};
        vecs[8]  = '{2'b10, 0, 0, 9, 32'h5, 0, 0, 9, 9,
                     32'h5, 32'h5, 2'b00};
        vecs[9]  = '{2'b00, 0, 0, 0, 0, 0, 0, 9, 9,
                     32'h5, 32'h5, 2'b00};
        vecs[10] = '{2'b01, 9, 32'h6, 0, 0, 1, 9, 9, 9,
                     32'h6, 32'h6, 2'b00};
        vecs[11] = '{2'b00, 0, 0, 0, 0, 0, 0, 9, 5,
                     32'h6, 32'hDEADBEEF, 2'b01};
        vecs[12] = '{2'b11, 12, 32'h1234, 13, 32'h5678, 0, 0, 12, 13,
                     32'h1234, 32'h5678, 2'b00};
        vecs[13] = '{2'b00, 0, 0, 0, 0, 0, 0, 13, 12,
                     32'h5678, 32'h1234, 2'b00};
        vecs[14] = '{2'b01, 3, 32'h77, 0, 0, 1, 3, 3, 9,
                     32'h77, 32'h6, 2'b10};
        vecs[15] = '{2'b00, 0, 0, 0, 0, 0, 0, 3, 3,
                     32'h77, 32'h77, 2'b11};

        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {27'd0, bus.init_done, bus.rd_data, bus.rd_busy,
            2'b00}, 96'd0);
        rst = 1'b0;
        run_init(cyc);
        chk("first_clear_len", 96'(cyc), 96'd32);

        for (int j = 1; j < 32; j++) begin
            drive(2'b01, 5'(j), 32'h1000 + j, 5'd0, 32'd0, 1'b0, 5'd0,
                  5'd0, 5'd0);
            @(posedge clk);
            #1;
        end
        idle();
        bus.rd_addr = {5'd31, 5'd17};
        #1;
        chk("preload", {32'd0, bus.rd_data}, {32'd0, 32'h101F, 32'h1011});

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_init(cyc);
        chk("clear_len", 96'(cyc), 96'd32);

        for (int r = 0; r < 32; r++) begin
            bus.rd_addr = {5'(31 - r), 5'(r)};
            #1;
            chk("cleared", {30'd0, bus.rd_data, bus.rd_busy}, 96'd0);
        end

        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].we, vecs[k].wa0, vecs[k].wd0, vecs[k].wa1,
                  vecs[k].wd1, vecs[k].bs, vecs[k].ba, vecs[k].ra0,
                  vecs[k].ra1);
            q_exp.push_back('{vecs[k].e0, vecs[k].e1, vecs[k].eb});
            @(negedge clk);
            ex = q_exp.pop_front();
            chk($sformatf("vec%0d", k),
                {30'd0, bus.rd_data, bus.rd_busy},
                {30'd0, ex.e1, ex.e0, ex.eb});
            @(posedge clk);
            #1;
        end
        idle();

        #1;
        chk("run_done", 96'(bus.init_done), 96'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rd_addr = {5'd9, 5'd3};
        #1;
        chk("mid_rst", {29'd0, bus.init_done, bus.rd_data, bus.rd_busy},
            96'd0);
        run_init(cyc);
        chk("mid_clear_len", 96'(cyc), 96'd32);
        bus.rd_addr = {5'd9, 5'd3};
        #1;
        chk("after_mid", {29'd0, bus.init_done, bus.rd_data, bus.rd_busy},
            {29'd1, 32'd0, 32'd0, 2'b00});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
